// File: rtl/aes_ctrl_pkg.sv
// Shared constants for the AES-128 round sequencer: one-hot state encoding,
// default round count and counter width.
package aes_ctrl_pkg;

  localparam int NR_AES128 = 10;
  localparam int CW_DEF    = 4;

  localparam int I_IDLE  = 0;
  localparam int I_LOAD  = 1;
  localparam int I_ROUND = 2;
  localparam int I_FINAL = 3;
  localparam int I_DONE  = 4;
  localparam int I_ALARM = 5;

  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_LOAD  = 6'b000010;
  localparam logic [5:0] S_ROUND = 6'b000100;
  localparam logic [5:0] S_FINAL = 6'b001000;
  localparam logic [5:0] S_DONE  = 6'b010000;
  localparam logic [5:0] S_ALARM = 6'b100000;

  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/dup_down_ctr.sv
// Down-counter kept alongside its bitwise complement; any disagreement between
// the two copies is reported as a mismatch.
module dup_down_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         mismatch
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cntn_q;

  // The complement copy counts up: ~(x - 1) == ~x + 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      cntn_q <= '1;
    end else if (load) begin
      cnt_q  <= load_val;
      cntn_q <= ~load_val;
    end else if (dec) begin
      cnt_q  <= cnt_q - W'(1);
      cntn_q <= cntn_q + W'(1);
    end
  end

  assign cnt      = cnt_q;
  assign mismatch = (cnt_q != ~cntn_q);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: load strobe, NR round enables with index,
// final-round flag, done pulse and a sticky fault alarm.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR = NR_AES128,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          ld_o,
  output logic          rnd_en,
  output logic          last_rnd,
  output logic [CW-1:0] round_idx,
  output logic          done,
  output logic          fault_alarm
);

  logic [5:0]    state_q, state_d;
  logic          fault_q;
  logic [CW-1:0] dcnt;
  logic          ctr_mis;
  logic          ctr_load, ctr_dec;
  logic          fault_det;
  logic          ok;

  assign ctr_load = state_q[I_LOAD];
  assign ctr_dec  = state_q[I_ROUND] | state_q[I_FINAL];

  dup_down_ctr #(.W(CW)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (CW'(NR)),
    .dec      (ctr_dec),
    .cnt      (dcnt),
    .mismatch (ctr_mis)
  );

  assign fault_det = ctr_mis | ~is_onehot6(state_q) | (state_q[I_ROUND] & (dcnt == '0));

  // The alarm flag is kept apart from the state vector so a corrupted state
  // register cannot also hide its own detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_q | fault_det;
    end
  end

  always_comb begin
    state_d = S_ALARM;
    if (!(fault_det || fault_q)) begin
      case (state_q)
        S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
        S_LOAD:  state_d = S_ROUND;
        S_ROUND: state_d = (dcnt > CW'(2)) ? S_ROUND : S_FINAL;
        S_FINAL: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_ALARM;
      endcase
    end
  end

  assign ok          = ~fault_q;
  assign busy        = ok & (state_q[I_LOAD] | state_q[I_ROUND] | state_q[I_FINAL] | state_q[I_DONE]);
  assign ld_o        = ok & state_q[I_LOAD];
  assign rnd_en      = ok & (state_q[I_ROUND] | state_q[I_FINAL]);
  assign last_rnd    = ok & state_q[I_FINAL];
  assign done        = ok & state_q[I_DONE];
  assign round_idx   = rnd_en ? (CW'(NR) - dcnt + CW'(1)) : '0;
  assign fault_alarm = fault_q | state_q[I_ALARM];

endmodule
